// File: rtl/sweep_cfg_pkg.sv
// sweep_cfg_pkg
//   Shared definitions for the sweep configuration sequencer:
//   layout of the 53-bit requester cfg word, frequency limits,
//   reset defaults, nack reason codes and FSM state encoding.
//   No ports (package).
package sweep_cfg_pkg;

  localparam int CFG_W = 53;

  // Packed cfg word, MSB first: {pulse, speed, range, mode, base}
  typedef struct packed {
    logic        pulse;
    logic [12:0] speed;
    logic [16:0] range;
    logic [1:0]  mode;
    logic [19:0] base;
  } cfg_t;

  localparam logic [19:0] FREQ_MIN = 20'd1000;
  localparam logic [19:0] FREQ_MAX = 20'd999000;

  localparam logic [19:0] RST_BASE_FREQ = 20'd100000;

  localparam logic [1:0] NACK_NONE  = 2'b00;
  localparam logic [1:0] NACK_BASE  = 2'b01;
  localparam logic [1:0] NACK_MODE  = 2'b10;
  localparam logic [1:0] NACK_SPEED = 2'b11;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_CHECK     = 3'd1;
  localparam logic [2:0] ST_CLAMP     = 3'd2;
  localparam logic [2:0] ST_WAIT_TICK = 3'd3;
  localparam logic [2:0] ST_RELEASE   = 3'd4;

endpackage

// File: rtl/sweep_cfg_sequencer_if.sv
// sweep_cfg_sequencer_if
//   Requester-side bus of the sweep configuration sequencer.
//   req       : per-requester update request, held until ack or nack
//   cfg_in    : per-requester packed cfg words (CFG_W bits each)
//   ack/nack  : per-requester 1-cycle result pulses
//   nack_code : reason for the most recent rejection
//   master = command sources, slave = sequencer.
interface sweep_cfg_sequencer_if #(parameter int N_REQ = 2);
  import sweep_cfg_pkg::*;

  logic [N_REQ-1:0]       req;
  logic [N_REQ*CFG_W-1:0] cfg_in;
  logic [N_REQ-1:0]       ack;
  logic [N_REQ-1:0]       nack;
  logic [1:0]             nack_code;

  modport master (output req, cfg_in, input ack, nack, nack_code);
  modport slave  (input req, cfg_in, output ack, nack, nack_code);
endinterface

// File: rtl/sweep_cfg_sequencer_rr_arbiter.sv
// rr_arbiter
//   Round-robin arbiter. Search starts at the index after the last
//   accepted grant; the pointer only moves when the grant is accepted.
//   clk, rst_n : clock, async active-low reset
//   req        : request vector
//   accept     : consumer takes the current grant this cycle
//   grant      : one-hot grant
//   grant_idx  : binary index of the grant
//   valid      : some request is pending
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             accept,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    grant_idx,
  output logic             valid
);

  logic [IW-1:0] ptr;

  // Scan the requests starting from the pointer, first hit wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!valid && req[idx]) begin
        valid      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

  // Move the pointer just past the requester that was served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept && valid) begin
      ptr <= (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + IW'(1);
    end
  end

endmodule

// File: rtl/sweep_cfg_sequencer.sv
// sweep_cfg_sequencer
//   Arbitrates sweep configuration requests, validates and clamps them,
//   and applies the accepted set atomically on a 1 ms boundary.
//   clk, rst_n    : clock, async active-low reset
//   req_bus       : requester bus (req/cfg_in in, ack/nack/nack_code out)
//   base_freq     : applied base frequency, Hz
//   sweep_mode    : applied sweep mode
//   sweep_range   : applied, clamped sweep range, Hz
//   sweep_speed   : applied sweep speed, Hz/ms
//   pulse_mode    : applied pulse-mode flag
//   sweep_restart : 1-cycle pulse with each apply
//   busy          : FSM not idle
module sweep_cfg_sequencer
  import sweep_cfg_pkg::*;
#(
  parameter int N_REQ         = 2,
  parameter int CYCLES_PER_MS = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sweep_cfg_sequencer_if.slave  req_bus,
  output logic [19:0]           base_freq,
  output logic [1:0]            sweep_mode,
  output logic [16:0]           sweep_range,
  output logic [12:0]           sweep_speed,
  output logic                  pulse_mode,
  output logic                  sweep_restart,
  output logic                  busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;

  logic [2:0]       state;
  logic [N_REQ-1:0] g_oh;
  cfg_t             cfg_lat;
  cfg_t             sel_cfg;
  logic [1:0]       mode_eff;
  logic [16:0]      range_eff;
  logic [CW-1:0]    ms_cnt;
  logic             tick;
  logic             req_g;
  logic [N_REQ-1:0] arb_grant;
  logic [IW-1:0]    arb_idx;
  logic             arb_valid;
  logic [1:0]       chk_code;
  logic [19:0]      dev_lo;
  logic [19:0]      dev_hi;
  logic [19:0]      max_dev;
  logic [16:0]      clamp_range;
  logic [1:0]       clamp_mode;

  rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_bus.req),
    .accept    (state == ST_IDLE),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .valid     (arb_valid)
  );

  assign sel_cfg = cfg_t'(req_bus.cfg_in[int'(arb_idx)*CFG_W +: CFG_W]);
  assign req_g   = |(req_bus.req & g_oh);
  assign busy    = (state != ST_IDLE);
  assign tick    = (ms_cnt == CW'(CYCLES_PER_MS - 1));

  // Free-running millisecond counter; it is never held or restarted by the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms_cnt <= '0;
    end else if (tick) begin
      ms_cnt <= '0;
    end else begin
      ms_cnt <= ms_cnt + CW'(1);
    end
  end

  // Validation of the latched request; earlier checks take priority.
  always_comb begin
    chk_code = NACK_NONE;
    if (!cfg_lat.pulse && (cfg_lat.base < FREQ_MIN || cfg_lat.base > FREQ_MAX)) begin
      chk_code = NACK_BASE;
    end else if (cfg_lat.mode == 2'b11) begin
      chk_code = NACK_MODE;
    end else if (cfg_lat.mode != 2'b00 && cfg_lat.speed == '0) begin
      chk_code = NACK_SPEED;
    end
  end

  // Range clamp. The subtractions only happen for pulse=0, where the base
  // has already been proven inside FREQ_MIN..FREQ_MAX, so nothing wraps.
  always_comb begin
    dev_lo      = '0;
    dev_hi      = '0;
    max_dev     = '0;
    clamp_range = '0;
    clamp_mode  = 2'b00;
    if (!cfg_lat.pulse) begin
      dev_lo      = cfg_lat.base - FREQ_MIN;
      dev_hi      = FREQ_MAX - cfg_lat.base;
      max_dev     = (dev_lo < dev_hi) ? dev_lo : dev_hi;
      clamp_range = ({3'b000, cfg_lat.range} < max_dev) ? cfg_lat.range : max_dev[16:0];
      clamp_mode  = cfg_lat.mode;
    end
  end

  // Main sequencer: grant, check, clamp, wait for the ms boundary, apply,
  // then hold until the served requester lets go of req.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      g_oh              <= '0;
      cfg_lat           <= '0;
      mode_eff          <= 2'b00;
      range_eff         <= '0;
      req_bus.ack       <= '0;
      req_bus.nack      <= '0;
      req_bus.nack_code <= NACK_NONE;
      base_freq         <= RST_BASE_FREQ;
      sweep_mode        <= 2'b00;
      sweep_range       <= '0;
      sweep_speed       <= '0;
      pulse_mode        <= 1'b0;
      sweep_restart     <= 1'b0;
    end else begin
      req_bus.ack   <= '0;
      req_bus.nack  <= '0;
      sweep_restart <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            g_oh    <= arb_grant;
            cfg_lat <= sel_cfg;
            state   <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (chk_code != NACK_NONE) begin
            req_bus.nack      <= g_oh;
            req_bus.nack_code <= chk_code;
            state             <= ST_RELEASE;
          end else begin
            state <= ST_CLAMP;
          end
        end
        ST_CLAMP: begin
          mode_eff  <= clamp_mode;
          range_eff <= clamp_range;
          state     <= ST_WAIT_TICK;
        end
        ST_WAIT_TICK: begin
          if (!req_g) begin
            state <= ST_IDLE;
          end else if (tick) begin
            base_freq     <= cfg_lat.base;
            sweep_mode    <= mode_eff;
            sweep_range   <= range_eff;
            sweep_speed   <= cfg_lat.speed;
            pulse_mode    <= cfg_lat.pulse;
            req_bus.ack   <= g_oh;
            sweep_restart <= 1'b1;
            state         <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!req_g) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
